mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequencer for the CPU's multiply/divide unit (MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO).
- Owns the HI/LO registers and models fixed multi-cycle latency for multiply and divide.
- Raises a stall request to the decode-stage hazard unit while an HI/LO-using instruction must wait.
- Sits beside the ALU in the execute stage. It is driven by E-stage decode outputs and read by the MFHI/MFLO forwarding path.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (must be >= 1)
- DIV_LAT, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is an MDU operation (qualifies op)
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  32  rt operand (divisor / multiplier)
- md_use  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall  out  1  stall request to hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: asynchronous on rst_n low. Clears state to IDLE, busy=0, count=0, hi=0, lo=0, pending results=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, BUSY.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, sampled at edge T:
  - Latch the computed pend_hi/pend_lo.
  - Load count = MULT_LAT or DIV_LAT.
  - Go to BUSY. busy=1 from T+1.
- BUSY, each edge: count decrements.
  - At the edge where count goes 1 -> 0: hi/lo take pend_hi/pend_lo, busy falls, state returns to IDLE.
  - busy is high for exactly LAT cycles. New hi/lo are visible in the first cycle busy is low.
- MTHI/MTLO in IDLE: hi (or lo) <= a at the same edge; no BUSY. The other register is unchanged.
- start while BUSY: ignored; no effect on count or pending results. The hazard unit guarantees this never occurs. The bench checks that it is ignored.
- op NONE/reserved with start=1: no effect.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: same, unsigned.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: same, unsigned.
  - Divisor zero: still BUSY for DIV_LAT cycles; hi/lo unchanged at completion.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- stall (combinational) = md_use & (busy | (start & op in {MULT, MULTU, DIV, DIVU})).
  - Falls in the cycle busy falls.
  - MTHI/MTLO start does not stall.
- hi/lo change only at completion edges, MTHI/MTLO edges, or reset.

Decomposition:
- Shared package mdu_pkg:
  - op code localparams (OP_NONE .. OP_MTLO)
  - state encodings (S_IDLE, S_BUSY)
  - default latency constants
- One sub-module, mdu_arith: purely combinational. Inputs a, b, op. Outputs res_hi, res_lo, div_zero.
- mdu_ctrl holds the FSM, counter, pending registers, HI/LO and the stall logic.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=5:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - stall=1 with md_use=1 during those cycles, 0 after.
- MULTU, a=0xFFFFFFFF, b=2: after 5 cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV, a=0xFFFFFFF9 (-7), b=2:
  - busy for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU by zero after MTHI a=0x12345678 and MTLO a=0x9ABCDEF0:
  - busy for 10 cycles; hi/lo still 0x12345678/0x9ABCDEF0.
  - MTHI/MTLO produce no busy.
- DIV, a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - A second start (MULT) injected mid-BUSY is ignored.
- MULT issued, rst_n driven low at busy cycle 3 between clock edges:
  - busy, hi and lo drop to 0 immediately.
  - After release: IDLE; a fresh MULT 2*3 gives lo=6 after 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op codes carried on the E-stage `op` bus
//   - controller state type
//   - default multiply/divide latencies
//   - is_md_op(): true for the op codes that occupy the unit for several cycles
package mdu_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    function automatic logic is_md_op(input logic [2:0] o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32-bit multiply/divide datapath.
//   a, b     : rs / rt operands
//   op       : operation code (mdu_pkg OP_*)
//   res_hi   : HI result (product upper half / remainder)
//   res_lo   : LO result (product lower half / quotient)
//   div_zero : DIV/DIVU with b == 0; HI/LO must then be left unchanged
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division via magnitudes: avoids simulator-dependent behaviour of
    // 0x80000000 / -1 (magnitude 0x80000000 / 1 gives the required 0x80000000).
    assign sgn   = (op == OP_DIV);
    assign a_neg = sgn & a[31];
    assign b_neg = sgn & b[31];
    assign mag_a = a_neg ? (32'd0 - a) : a;
    assign mag_b = b_neg ? (32'd0 - b) : b;

    assign div_zero = (b == '0);

    always_comb begin
        uq = '0;
        ur = '0;
        if (!div_zero) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
    end

    assign quot = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign rem  = a_neg ? (32'd0 - ur) : ur;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV,
            OP_DIVU: begin
                res_hi = rem;
                res_lo = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer, owner of HI/LO.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start, op  : E-stage MDU instruction and its op code
//   a, b       : rs / rt operands
//   md_use     : D-stage instruction uses the MDU or HI/LO
//   busy       : multiply/divide in flight (high for exactly LAT cycles)
//   stall      : stall request to the hazard unit
//   hi, lo     : architectural HI/LO registers
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;
    logic             load;
    logic             finish;
    logic             idle;
    logic             is_div;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_zero;

    mdu_arith u_arith (
        .a        (a),
        .b        (b),
        .op       (op),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign idle   = (state_q == S_IDLE);
    assign busy   = (state_q == S_BUSY);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign stall  = md_use & (busy | (start & is_md_op(op)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && is_md_op(op)) begin
                    state_d = S_BUSY;
                    load    = 1'b1;
                end
            end
            S_BUSY: begin
                if (count_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Divide by zero still runs the full latency; pend_wr=0 suppresses the
    // HI/LO update at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (load) begin
            count_q <= is_div ? DIV_LD : MULT_LD;
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= !(is_div && div_zero);
        end else if (busy) begin
            count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            if (pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (idle && start) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .md_use (md_use),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge. Issues one op, counts busy/stall cycles
    // (bounded), optionally injects a MULT start at busy cycle inject_at.
    task automatic run_op(input string name, input logic [2:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int lat, input logic [31:0] eh,
                          input logic [31:0] el, input int inject_at);
        int n;
        int st;
        start  = 1'b1;
        op     = o;
        a      = av;
        b      = bv;
        md_use = 1'b1;
        #1 check({name, "_issue_stall"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = OP_NONE;
        a     = '0;
        b     = '0;
        n  = 0;
        st = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (start) begin
                start = 1'b0;
                op    = OP_NONE;
                a     = '0;
                b     = '0;
                #1;
            end
            if (!busy) break;
            n++;
            if (stall) st++;
            if (n == inject_at) begin
                start = 1'b1;
                op    = OP_MULT;
                a     = 32'h7;
                b     = 32'h7;
            end
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(lat));
        check({name, "_stall_cycles"}, 32'(st), 32'(lat));
        check({name, "_stall_after"}, 32'(stall), 32'd0);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
    endtask

    task automatic move_to(input string name, input logic [2:0] o,
                           input logic [31:0] av, input logic [31:0] eh,
                           input logic [31:0] el);
        start  = 1'b1;
        op     = o;
        a      = av;
        md_use = 1'b1;
        #1 check({name, "_stall"}, 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = OP_NONE;
        a     = '0;
        @(negedge clk);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = OP_NONE;
        a      = '0;
        b      = '0;
        md_use = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // NONE / reserved with start: no stall, no busy
        start = 1'b1; op = OP_NONE; md_use = 1'b1; a = 32'h55; b = 32'h3;
        #1 check("none_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("none_busy", 32'(busy), 32'd0);
        op = 3'd7;
        #1 check("rsvd_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_lo", lo, 32'd0);
        start = 1'b0;

        run_op("mult",  OP_MULT,  32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, 0);
        run_op("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);

        move_to("mthi", OP_MTHI, 32'h12345678, 32'h12345678, 32'hFFFFFFFD);
        move_to("mtlo", OP_MTLO, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0);
        run_op("divu0", OP_DIVU, 32'h00001234, 32'd0, 10, 32'h12345678, 32'h9ABCDEF0, 0);

        run_op("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 4);

        // Asynchronous reset in the middle of a multiply
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0; op = OP_NONE; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_lo", lo, 32'd0);
        run_op("mult_after_rst", OP_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
